// File: rtl/rca_32.sv
// Registered ripple-carry adder: {cout, sum} = A + B + cin, one cycle after sampling.
// The carry chain is built bit by bit from full-adder cells so no lookahead logic is inferred.
module rca_32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum_comb[i]  = A[i] ^ B[i] ^ carry[i];
    assign carry[i + 1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
  end

  // Reset overrides the freshly computed result so no stale sum survives it.
  always_comb begin
    sum_d  = sum_comb;
    cout_d = carry[WIDTH];
    if (rst) begin
      sum_d  = '0;
      cout_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    sum_q  <= sum_d;
    cout_q <= cout_d;
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_rca_32.sv
// Directed bench for rca_32: expected {cout, sum} values are queued when operands are driven
// and popped when the registered result is due one cycle later.
module tb_rca_32;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic        cin;
  logic [31:0] sum;
  logic        cout;

  int checks;
  int errors;

  logic [32:0] exp_q[$];
  string       tag_q[$];

  rca_32 #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic c);
    return {1'b0, a} + {1'b0, b} + {32'd0, c};
  endfunction

  task automatic check_result();
    logic [32:0] exp;
    string       tag;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d,%0d required=pending entry", cout, sum);
    end else begin
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      assert ({cout, sum} === exp) else begin
        errors++;
        $error("FAIL %s observed cout=%0d sum=%0d required cout=%0d sum=%0d",
               tag, cout, sum, exp[32], exp[31:0]);
      end
    end
  endtask

  // Drive one set of inputs, let the DUT sample them, then compare on the falling edge.
  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b,
                      input logic c, input logic [32:0] exp, input string tag);
    rst = r;
    A   = a;
    B   = b;
    cin = c;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    check_result();
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rc;
    checks = 0;
    errors = 0;

    step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'd0, "reset_hold_max");
    step(1'b1, 32'd1234, 32'd5678, 1'b0, 33'd0, "reset_second");

    step(1'b0, 32'd4294967290, 32'd4294967294, 1'b0, {1'b1, 32'd4294967288}, "big_overflow");
    step(1'b0, 32'd1, 32'd4294967295, 1'b0, {1'b1, 32'd0}, "full_propagate");
    step(1'b0, 32'd1005, 32'd69, 1'b1, {1'b0, 32'd1075}, "small_cin");
    step(1'b0, 32'd151242, 32'd53831224, 1'b1, {1'b0, 32'd53982467}, "mid_cin");
    step(1'b0, 32'd501, 32'd5002423, 1'b0, {1'b0, 32'd5002924}, "mid_nocin");
    step(1'b0, 32'd0, 32'd0, 1'b0, {1'b0, 32'd0}, "zeros");
    step(1'b0, 32'd4294967295, 32'd4294967295, 1'b1, {1'b1, 32'd4294967295}, "all_ones_cin");
    step(1'b0, 32'd0, 32'd0, 1'b1, {1'b0, 32'd1}, "cin_only");
    step(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, {1'b1, 32'd0}, "alt_bits_cin");

    // Held inputs must keep the output steady.
    step(1'b0, 32'd777, 32'd223, 1'b0, {1'b0, 32'd1000}, "hold_0");
    step(1'b0, 32'd777, 32'd223, 1'b0, {1'b0, 32'd1000}, "hold_1");
    step(1'b0, 32'd777, 32'd223, 1'b0, {1'b0, 32'd1000}, "hold_2");

    // Back-to-back random operands, one result per cycle.
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      step(1'b0, ra, rb, rc, model(ra, rb, rc), $sformatf("b2b_%0d", i));
    end

    // Reset discards the in-flight result; release loads the same inputs.
    step(1'b0, 32'd100, 32'd200, 1'b0, {1'b0, 32'd300}, "pre_reset");
    step(1'b1, 32'd4294967295, 32'd1, 1'b1, 33'd0, "reset_mid_run");
    step(1'b0, 32'd4294967295, 32'd1, 1'b1, {1'b1, 32'd1}, "post_reset");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d entries required=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_32.md
RCA_32 -- requirements
Module: rca_32

Interface
REQ-001 Parameter WIDTH, default 32, operand and sum bit width; the bench uses 32 only.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 A  input  WIDTH  unsigned addend A.
REQ-005 B  input  WIDTH  unsigned addend B.
REQ-006 cin  input  1  carry-in to bit 0.
REQ-007 sum  output  WIDTH  registered low WIDTH bits of A+B+cin.
REQ-008 cout  output  1  registered carry-out of bit WIDTH-1.
REQ-009 One clock; reset is synchronous and active-high (clk, rst); the polarity and synchronicity are fixed.

Function
REQ-010 The adder core SHALL be a true ripple-carry chain of WIDTH full-adder cells; no lookahead, select or prefix logic.
REQ-011 Each full-adder cell SHALL compute s = a^b^c and co = (a&b)|(a&c)|(b&c).
REQ-012 Bit 0 carry-in SHALL be cin; bit i carry-in SHALL be bit i-1 carry-out; cout SHALL come from bit WIDTH-1.
REQ-013 {cout,sum} SHALL equal A+B+cin as an unsigned WIDTH+1-bit value; range 0 to 2^(WIDTH+1)-1.
REQ-014 Overflow beyond WIDTH bits SHALL appear only on cout; sum wraps modulo 2^WIDTH.
REQ-015 A, B and cin are sampled on every rising edge with rst low; no enable or handshake exists.
REQ-016 Latency SHALL be exactly 1 cycle: result of inputs sampled at edge N is visible on sum/cout after edge N.
REQ-017 Throughput SHALL be one addition per cycle; back-to-back input changes each produce their own result one cycle later.
REQ-018 Inputs held constant SHALL leave outputs constant from the cycle after sampling.
REQ-019 The full ripple path from A/B/cin to the output registers SHALL fit in one clk period; no internal pipelining.
REQ-020 X/Z on inputs is out of scope; behaviour is undefined.

Reset
REQ-021 While rst is high at a rising edge, sum SHALL load 0 and cout SHALL load 0, regardless of A, B and cin.
REQ-022 A result computed in the cycle where rst is asserted SHALL be discarded; no stale result appears after reset.
REQ-023 On the first rising edge with rst low, outputs SHALL load the result of the inputs present at that edge.
REQ-024 Output values before the first reset edge are undefined; the bench SHALL assert rst for at least 1 cycle at start.

Verification
REQ-025 A=4294967290, B=4294967294, cin=0 -> one cycle later sum=4294967288, cout=1.
REQ-026 A=1, B=4294967295, cin=0 -> sum=0, cout=1 (full carry propagation through all 32 bits).
REQ-027 A=1005, B=69, cin=1 -> sum=1075, cout=0; then A=151242, B=53831224, cin=1 -> sum=53982467, cout=0.
REQ-028 A=501, B=5002423, cin=0 -> sum=5002924, cout=0; A=0, B=0, cin=0 -> sum=0, cout=0; A=4294967295, B=4294967295, cin=1 -> sum=4294967295, cout=1.
REQ-029 Apply new operands on consecutive edges -> each result appears exactly one cycle after its operands, with no skipped or duplicated result.
REQ-030 Assert rst for one edge while A=4294967295, B=1, cin=1 -> sum=0, cout=0 after that edge; deassert -> the next edge gives sum=1, cout=1.
